decipher_param: RTL

DECIPHER_PARAM -- requirements
Module: decipher_param

---
 rtl/decipher_param.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decipher_param.sv
// decipher_param: three-stage unpacker and binner for raw 96-bit track words.
// Stage 1 captures the raw word and its sector, stage 2 computes the pT clamp
// and the eta/z/phi bins, stage 3 holds the packed output word. A single
// advance enable stalls every stage together when the consumer back-pressures.
// Side counters report dropped (out-of-range sector) tracks and the number of
// tracks emitted per event.
module decipher_param #(
   parameter int NPHI           = 27,
   parameter int NSECTOR        = 9,
   parameter int PHI_PER_SECTOR = 3,
   parameter int NZBIN          = 8,
   parameter int NETA           = 24,
   parameter int PT_W           = 9,
   parameter int PT_SHIFT       = 4,
   localparam int PHI_W         = $clog2(NPHI),
   localparam int Z_W           = $clog2(NZBIN),
   localparam int ETA_W         = $clog2(NETA),
   localparam int TRACK_W       = PHI_W + 2*Z_W + ETA_W + PT_W + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [95:0]        track_in,
   input  logic [4:0]         phi_sector,
   input  logic               eoe,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TRACK_W-1:0] track,
   output logic               pt_sat,
   output logic [15:0]        evt_count,
   output logic               evt_count_valid,
   output logic [15:0]        drop_count
);

   // 32-bit views of the parameters so all bin arithmetic runs at one width
   localparam logic [31:0] NPHI_U    = 32'(NPHI);
   localparam logic [31:0] NSECTOR_U = 32'(NSECTOR);
   localparam logic [31:0] PPS_U     = 32'(PHI_PER_SECTOR);
   localparam logic [31:0] NZBIN_U   = 32'(NZBIN);
   localparam logic [31:0] NETA_U    = 32'(NETA);
   localparam logic [31:0] PT_MAX_U  = (32'd1 << PT_W) - 32'd1;

   // ------------------------------------------------------------------
   // Arithmetic helpers
   // ------------------------------------------------------------------

   // Shifted pT, clamped to the output width
   function automatic logic [PT_W-1:0] calc_pt(input logic [13:0] p);
      logic [31:0] sh;
      logic [PT_W-1:0] r;
      sh = {18'd0, p} >> PT_SHIFT;
      if (sh > PT_MAX_U) begin
         r = PT_MAX_U[PT_W-1:0];
      end else begin
         r = sh[PT_W-1:0];
      end
      return r;
   endfunction

   // Flags that the shifted pT did not fit and was clamped
   function automatic logic calc_sat(input logic [13:0] p);
      logic [31:0] sh;
      sh = {18'd0, p} >> PT_SHIFT;
      return (sh > PT_MAX_U);
   endfunction

   // Offset-binary eta scaled onto NETA bins; result is always < NETA
   function automatic logic [ETA_W-1:0] calc_eta(input logic [15:0] e);
      logic [31:0] prod;
      logic [31:0] sh;
      prod = {16'd0, e} * NETA_U;
      sh   = prod >> 16;
      return sh[ETA_W-1:0];
   endfunction

   // Two's-complement z shifted to unsigned: adding 2048 flips the sign bit
   function automatic logic [11:0] z_unsigned(input logic [11:0] z);
      return {~z[11], z[10:0]};
   endfunction

   // Lower z bin
   function automatic logic [Z_W-1:0] calc_zbin1(input logic [11:0] z);
      logic [31:0] prod;
      logic [31:0] sh;
      prod = {20'd0, z_unsigned(z)} * NZBIN_U;
      sh   = prod >> 12;
      return sh[Z_W-1:0];
   endfunction

   // Half-bin shifted z bin, clamped to the last bin at the top edge
   function automatic logic [Z_W-1:0] calc_zbin2(input logic [11:0] z);
      logic [31:0] prod;
      logic [31:0] sh;
      prod = {20'd0, z_unsigned(z)} * NZBIN_U;
      sh   = (prod + 32'd2048) >> 12;
      if (sh > (NZBIN_U - 32'd1)) begin
         sh = NZBIN_U - 32'd1;
      end else begin
         sh = sh;
      end
      return sh[Z_W-1:0];
   endfunction

   // Global phi bin: sector base plus fractional position, wrapped at NPHI
   function automatic logic [PHI_W-1:0] calc_phi(input logic [4:0] sec,
                                                 input logic [11:0] rel);
      logic [31:0] frac;
      logic [31:0] sum;
      frac = ({20'd0, rel} * PPS_U) >> 12;
      sum  = ({27'd0, sec} * PPS_U) + frac;
      if (sum >= NPHI_U) begin
         sum = sum - NPHI_U;
      end else begin
         sum = sum;
      end
      return sum[PHI_W-1:0];
   endfunction

   // Saturating 16-bit increment
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      logic [15:0] r;
      if (inc && (v != 16'hFFFF)) begin
         r = v + 16'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic               en;
   logic               in_ok;
   logic               hs;

   logic               s1_valid;
   logic [13:0]        s1_pt;
   logic [11:0]        s1_rel;
   logic [15:0]        s1_eta;
   logic [11:0]        s1_z;
   logic [4:0]         s1_sec;
   logic               s1_bitx;

   logic [PT_W-1:0]    c_pt;
   logic               c_sat;
   logic [ETA_W-1:0]   c_eta;
   logic [Z_W-1:0]     c_z1;
   logic [Z_W-1:0]     c_z2;
   logic [PHI_W-1:0]   c_phi;

   logic               s2_valid;
   logic [TRACK_W-1:0] s2_track;
   logic               s2_sat;

   logic [15:0]        cnt;
   logic [15:0]        cnt_next;
   logic [15:0]        drop_next;

   // Raw-word fields that carry no information for binning
   logic               unused_bits;
   assign unused_bits = ^{track_in[94:55], track_in[14]};

   // Advance enable, sector range check, stage-2 arithmetic and counter next-states
   always_comb begin
      en        = !out_valid || out_ready;
      in_ok     = ({27'd0, phi_sector} < NSECTOR_U);
      hs        = out_valid && out_ready;
      c_pt      = calc_pt(s1_pt);
      c_sat     = calc_sat(s1_pt);
      c_eta     = calc_eta(s1_eta);
      c_z1      = calc_zbin1(s1_z);
      c_z2      = calc_zbin2(s1_z);
      c_phi     = calc_phi(s1_sec, s1_rel);
      cnt_next  = sat_inc(cnt, hs);
      drop_next = sat_inc(drop_count, in_valid && en && !in_ok);
   end

   assign in_ready = en;

   // Stage 1: capture the raw word; out-of-range sectors enter as bubbles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_pt    <= 14'd0;
         s1_rel   <= 12'd0;
         s1_eta   <= 16'd0;
         s1_z     <= 12'd0;
         s1_sec   <= 5'd0;
         s1_bitx  <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid && in_ok;
         s1_pt    <= track_in[13:0];
         s1_rel   <= track_in[26:15];
         s1_eta   <= track_in[42:27];
         s1_z     <= track_in[54:43];
         s1_sec   <= phi_sector;
         s1_bitx  <= track_in[95];
      end else begin
         s1_valid <= s1_valid;
      end
   end

   // Stage 2: register the packed binned word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_track <= '0;
         s2_sat   <= 1'b0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_track <= {c_phi, c_z1, c_z2, c_eta, c_pt, s1_bitx};
         s2_sat   <= c_sat;
      end else begin
         s2_valid <= s2_valid;
      end
   end

   // Stage 3: output register, held while the consumer stalls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         track     <= '0;
         pt_sat    <= 1'b0;
      end else if (en) begin
         out_valid <= s2_valid;
         track     <= s2_track;
         pt_sat    <= s2_sat;
      end else begin
         out_valid <= out_valid;
      end
   end

   // Cumulative tally of tracks rejected for an out-of-range sector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count <= 16'd0;
      end else begin
         drop_count <= drop_next;
      end
   end

   // Per-event emitted-track counter; eoe snapshots it (including this cycle's handshake)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt             <= 16'd0;
         evt_count       <= 16'd0;
         evt_count_valid <= 1'b0;
      end else if (eoe) begin
         cnt             <= 16'd0;
         evt_count       <= cnt_next;
         evt_count_valid <= 1'b1;
      end else begin
         cnt             <= cnt_next;
         evt_count_valid <= 1'b0;
      end
   end

endmodule
